fetch_align: RTL and testbench

Fetch aligner between the unified instruction/data memory and the decode stage of the pipelined RV32IMC core. It issues word-aligned fetch addresses and accepts returned words on fetch slots. It buffers halfwords and delivers one complete instruction per cycle, either 16-bit compressed or 32-bit, together with its PC. Decompression is done downstream; this block only frames instructions, including 32-bit instructions that straddle a word boundary.

---
 rtl/fetch_align.sv | 119 +++++++++++
 tb/tb_fetch_align.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_align.sv
// Fetch aligner: buffers up to three halfwords from word-aligned fetches and frames
// one 16-bit or 32-bit instruction per cycle for decode, including word-straddling ones.
module fetch_align #(
  parameter int                 ADDR_W   = 9,
  parameter logic [ADDR_W-1:0]  RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_valid,
  input  logic [31:0]       mem_word,
  output logic [ADDR_W-1:0] fetch_addr,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              stall,
  output logic              inst_valid,
  output logic [31:0]       inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              is_compressed
);

  localparam logic [ADDR_W-1:0] PC_STEP_HALF = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] PC_STEP_WORD = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] PC_HALF_MASK = ~ADDR_W'(1);
  localparam logic [ADDR_W-1:0] PC_WORD_MASK = ~ADDR_W'(3);

  logic [47:0]       r_hbuf;
  logic [1:0]        r_count;
  logic [ADDR_W-1:0] r_head_pc;
  logic [ADDR_W-1:0] r_fetch_addr;
  logic              r_skip_lo;

  logic              w_is_c;
  logic              w_inst_valid;
  logic              w_consume;
  logic              w_append;
  logic [47:0]       w_shift;
  logic [1:0]        w_rem;
  logic [47:0]       w_hbuf_nxt;
  logic [1:0]        w_count_nxt;

  assign w_is_c       = (r_hbuf[1:0] != 2'b11);
  assign w_inst_valid = (r_count != 2'd0) && (w_is_c || (r_count >= 2'd2));
  assign w_consume    = w_inst_valid & ~stall & ~redirect;
  // Occupancy is sampled before this cycle's consume, so a full-ish buffer drops the word.
  assign w_append     = mem_valid & ~redirect & (r_count <= 2'd1);

  // Next buffer contents: drop the consumed head, then stack the new word above what remains.
  always_comb begin
    w_shift     = r_hbuf;
    w_rem       = r_count;
    w_hbuf_nxt  = r_hbuf;
    w_count_nxt = r_count;
    if (w_consume) begin
      if (w_is_c) begin
        w_shift = {16'h0000, r_hbuf[47:16]};
        w_rem   = r_count - 2'd1;
      end else begin
        w_shift = {32'h0000_0000, r_hbuf[47:32]};
        w_rem   = r_count - 2'd2;
      end
    end else begin
      w_shift = r_hbuf;
      w_rem   = r_count;
    end
    if (w_append) begin
      if (r_skip_lo) begin
        case (w_rem)
          2'd0:    w_hbuf_nxt = {32'h0000_0000, mem_word[31:16]};
          default: w_hbuf_nxt = {16'h0000, mem_word[31:16], w_shift[15:0]};
        endcase
        w_count_nxt = w_rem + 2'd1;
      end else begin
        case (w_rem)
          2'd0:    w_hbuf_nxt = {16'h0000, mem_word};
          default: w_hbuf_nxt = {mem_word, w_shift[15:0]};
        endcase
        w_count_nxt = w_rem + 2'd2;
      end
    end else begin
      w_hbuf_nxt  = w_shift;
      w_count_nxt = w_rem;
    end
  end

  // Buffer, PC and fetch-pointer state; redirect flushes everything and overrides traffic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hbuf       <= 48'h0;
      r_count      <= 2'd0;
      r_head_pc    <= RESET_PC;
      r_fetch_addr <= RESET_PC & PC_WORD_MASK;
      r_skip_lo    <= RESET_PC[1];
    end else if (redirect) begin
      r_hbuf       <= 48'h0;
      r_count      <= 2'd0;
      r_head_pc    <= redirect_pc & PC_HALF_MASK;
      r_fetch_addr <= redirect_pc & PC_WORD_MASK;
      r_skip_lo    <= redirect_pc[1];
    end else begin
      r_hbuf  <= w_hbuf_nxt;
      r_count <= w_count_nxt;
      if (w_consume) begin
        r_head_pc <= r_head_pc + (w_is_c ? PC_STEP_HALF : PC_STEP_WORD);
      end
      if (w_append) begin
        r_fetch_addr <= r_fetch_addr + PC_STEP_WORD;
        r_skip_lo    <= 1'b0;
      end
    end
  end

  assign fetch_addr    = r_fetch_addr;
  assign inst_valid    = w_inst_valid;
  assign inst          = w_is_c ? {16'h0000, r_hbuf[15:0]} : r_hbuf[31:0];
  assign inst_pc       = r_head_pc;
  // An empty buffer reads as zeros, so it must not report a compressed instruction.
  assign is_compressed = (r_count != 2'd0) & w_is_c;

endmodule

// File: tb/tb_fetch_align.sv
// Bench for fetch_align: directed scenarios plus randomized traffic compared against a
// halfword-queue reference model of the instruction stream.
module tb_fetch_align;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid;
  logic [31:0] mem_word;
  logic [8:0]  fetch_addr;
  logic        redirect;
  logic [8:0]  redirect_pc;
  logic        stall;
  logic        inst_valid;
  logic [31:0] inst;
  logic [8:0]  inst_pc;
  logic        is_compressed;

  logic [31:0] mem [0:127];
  logic [15:0] q [$];
  logic [8:0]  m_pc;
  logic [8:0]  m_fa;
  logic        m_skip;
  int          n_checks = 0;
  int          n_pass   = 0;

  fetch_align #(.ADDR_W(9), .RESET_PC(9'd0)) dut (
    .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_word(mem_word),
    .fetch_addr(fetch_addr), .redirect(redirect), .redirect_pc(redirect_pc),
    .stall(stall), .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
    .is_compressed(is_compressed)
  );

  always #5 clk = ~clk;
  assign mem_word = mem[fetch_addr[8:2]];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
  endtask

  function automatic logic m_valid();
    return (q.size() >= 1) && ((q[0][1:0] != 2'b11) || (q.size() >= 2));
  endfunction

  task automatic model_reset();
    q.delete();
    m_pc = 9'd0; m_fa = 9'd0; m_skip = 1'b0;
  endtask

  task automatic model_edge(input logic mv, input logic st, input logic rd, input logic [8:0] rpc);
    logic [31:0] w;
    int n0;
    if (rd) begin
      q.delete();
      m_fa = {rpc[8:2], 2'b00}; m_pc = {rpc[8:1], 1'b0}; m_skip = rpc[1];
    end else begin
      n0 = q.size();
      if (m_valid() && !st) begin
        if (q[0][1:0] != 2'b11) begin
          void'(q.pop_front()); m_pc = m_pc + 9'd2;
        end else begin
          void'(q.pop_front()); void'(q.pop_front()); m_pc = m_pc + 9'd4;
        end
      end
      if (mv && n0 <= 1) begin
        w = mem[m_fa[8:2]];
        if (!m_skip) q.push_back(w[15:0]);
        q.push_back(w[31:16]);
        m_skip = 1'b0;
        m_fa = m_fa + 9'd4;
      end
    end
  endtask

  task automatic compare_all();
    logic [31:0] exp_inst;
    check_eq("inst_valid", 32'(inst_valid), 32'(m_valid()));
    check_eq("fetch_addr", 32'(fetch_addr), 32'(m_fa));
    check_eq("inst_pc", 32'(inst_pc), 32'(m_pc));
    if (m_valid()) begin
      exp_inst = (q[0][1:0] != 2'b11) ? {16'h0000, q[0]} : {q[1], q[0]};
      check_eq("inst", inst, exp_inst);
      check_eq("is_compressed", 32'(is_compressed), 32'(q[0][1:0] != 2'b11));
    end
  endtask

  task automatic step(input logic mv, input logic st, input logic rd, input logic [8:0] rpc);
    mem_valid = mv; stall = st; redirect = rd; redirect_pc = rpc;
    @(posedge clk);
    model_edge(mv, st, rd, rpc);
    @(negedge clk);
    compare_all();
  endtask

  task automatic pulse_reset();
    mem_valid = 1'b0; stall = 1'b0; redirect = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_eq("rst_inst_valid", 32'(inst_valid), 32'd0);
    check_eq("rst_fetch_addr", 32'(fetch_addr), 32'd0);
    check_eq("rst_inst_pc", 32'(inst_pc), 32'd0);
    check_eq("rst_inst", inst, 32'd0);
    check_eq("rst_is_c", 32'(is_compressed), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = $urandom;
    rst = 1'b1; mem_valid = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 9'd0;
    model_reset();
    repeat (2) @(negedge clk);
    check_eq("reset_fetch_addr", 32'(fetch_addr), 32'd0);
    check_eq("reset_inst_valid", 32'(inst_valid), 32'd0);
    check_eq("reset_inst", inst, 32'd0);
    check_eq("reset_is_c", 32'(is_compressed), 32'd0);
    check_eq("reset_inst_pc", 32'(inst_pc), 32'd0);
    rst = 1'b0;

    // First slot after reset delivers a full 32-bit instruction.
    mem[0] = 32'h0000_2083;
    step(1'b1, 1'b0, 1'b0, 9'd0);
    check_eq("t1_fetch_addr", 32'(fetch_addr), 32'd4);
    check_eq("t1_inst", inst, 32'h0000_2083);
    check_eq("t1_valid", 32'(inst_valid), 32'd1);
    check_eq("t1_is_c", 32'(is_compressed), 32'd0);

    // Two compressed then one 32-bit from words at 56 and 60.
    mem[14] = 32'h1881_4008; mem[15] = 32'hFE00_0093;
    step(1'b0, 1'b0, 1'b1, 9'd56);
    step(1'b1, 1'b0, 1'b0, 9'd0);
    check_eq("t2_inst0", inst, 32'h0000_4008);
    check_eq("t2_pc0", 32'(inst_pc), 32'd56);
    step(1'b1, 1'b0, 1'b0, 9'd0);
    check_eq("t2_inst1", inst, 32'h0000_1881);
    check_eq("t2_pc1", 32'(inst_pc), 32'd58);
    step(1'b1, 1'b0, 1'b0, 9'd0);
    check_eq("t2_inst2", inst, 32'hFE00_0093);
    check_eq("t2_pc2", 32'(inst_pc), 32'd60);

    // Straddling 32-bit instruction at PC 2.
    mem[0] = 32'h0093_0001; mem[1] = 32'h0000_FE00;
    step(1'b0, 1'b0, 1'b1, 9'd0);
    step(1'b1, 1'b0, 1'b0, 9'd0);
    check_eq("t3_inst0", inst, 32'h0000_0001);
    step(1'b0, 1'b0, 1'b0, 9'd0);
    check_eq("t3_wait_valid", 32'(inst_valid), 32'd0);
    step(1'b1, 1'b0, 1'b0, 9'd0);
    check_eq("t3_inst1", inst, 32'hFE00_0093);
    check_eq("t3_pc1", 32'(inst_pc), 32'd2);

    // Stall with two halfwords buffered: words are dropped, address held.
    step(1'b0, 1'b0, 1'b1, 9'd56);
    step(1'b1, 1'b0, 1'b0, 9'd0);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b1, 1'b0, 9'd0);
      check_eq("t4_hold_inst", inst, 32'h0000_4008);
      check_eq("t4_hold_fa", 32'(fetch_addr), 32'd60);
    end
    step(1'b0, 1'b0, 1'b0, 9'd0);
    step(1'b1, 1'b0, 1'b0, 9'd0);
    check_eq("t4_refetch_fa", 32'(fetch_addr), 32'd64);
    check_eq("t4_refetch_inst", inst, 32'hFE00_0093);

    // Redirect to a halfword target with a word arriving in the same cycle.
    mem[47] = 32'h9209_4645;
    step(1'b1, 1'b0, 1'b1, 9'd190);
    check_eq("t5_fa", 32'(fetch_addr), 32'd188);
    check_eq("t5_valid", 32'(inst_valid), 32'd0);
    step(1'b1, 1'b0, 1'b0, 9'd0);
    check_eq("t5_inst", inst, 32'h0000_9209);
    check_eq("t5_pc", 32'(inst_pc), 32'd190);
    check_eq("t5_is_c", 32'(is_compressed), 32'd1);

    // Build three buffered halfwords, then hit asynchronous reset mid-cycle.
    step(1'b0, 1'b0, 1'b1, 9'd56);
    step(1'b1, 1'b0, 1'b0, 9'd0);
    step(1'b0, 1'b0, 1'b0, 9'd0);
    step(1'b1, 1'b1, 1'b0, 9'd0);
    pulse_reset();

    // Randomized traffic, including wrap-around targets and another reset.
    for (int i = 0; i < 128; i++) mem[i] = $urandom;
    for (int c = 0; c < 3000; c++) begin
      logic [8:0] rpc;
      rpc = 9'($urandom) & 9'h1FE;
      if ($urandom_range(0, 3) == 0) rpc = 9'h1F8 | (9'($urandom) & 9'h006);
      if (c == 1500) pulse_reset();
      step(1'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 31) == 0), rpc);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
